// File: rtl/lzd_forty_eight.sv
// Registered 48-bit leading-zero detector: six 8-bit group detectors feed a
// priority combiner; count and nonzero flag are registered for 1-cycle latency.
module lzd_forty_eight (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] a,
    output logic [5:0]  p,
    output logic        v
);

    logic [5:0] p_q, p_d;
    logic       v_q, v_d;

    logic [2:0] grp_cnt [6];
    logic [5:0] grp_nz;

    // In-group count: 0 when the group MSB is set, 7 when only the LSB is set.
    function automatic logic [2:0] grp_lzc(input logic [7:0] g);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) begin
                cnt = 3'(7 - i);
            end
        end
        return cnt;
    endfunction

    always_comb begin
        for (int g = 0; g < 6; g++) begin
            grp_cnt[g] = grp_lzc(a[47 - 8*g -: 8]);
            grp_nz[g]  = |a[47 - 8*g -: 8];
        end
    end

    // Scan from the LSB-side group upward so the MSB-most nonzero group wins.
    always_comb begin
        p_d = 6'd0;
        v_d = |grp_nz;
        for (int k = 5; k >= 0; k--) begin
            if (grp_nz[k]) begin
                p_d = {3'(k), 3'b000} + {3'b000, grp_cnt[k]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= 6'd0;
            v_q <= 1'b0;
        end else begin
            p_q <= p_d;
            v_q <= v_d;
        end
    end

    assign p = p_q;
    assign v = v_q;

endmodule

// File: tb/tb_lzd_forty_eight.sv
// Scoreboard bench for lzd_forty_eight: driver queues expected results, a
// monitor pops and compares one cycle after each operand is sampled.
module tb_lzd_forty_eight;

    logic        clk;
    logic        rst;
    logic [47:0] a;
    logic [5:0]  p;
    logic        v;

    typedef struct packed {
        logic [5:0] p;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lzd_forty_eight dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .p   (p),
        .v   (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] ap, input logic av,
                         input logic [5:0] ep, input logic ev);
        n_checks++;
        if (ap !== ep || av !== ev) begin
            n_fail++;
            $display("FAIL %s: got p=%0d v=%0b, expected p=%0d v=%0b", name, ap, av, ep, ev);
        end
    endtask

    // Independent reference: scan from the MSB counting zeros.
    task automatic ref_lzc(input logic [47:0] val, output logic [5:0] ep, output logic ev);
        int  cnt;
        bit  found;
        cnt   = 0;
        found = 0;
        for (int i = 47; i >= 0; i--) begin
            if (!found) begin
                if (val[i]) found = 1;
                else cnt++;
            end
        end
        ev = |val;
        ep = ev ? 6'(cnt) : 6'd0;
    endtask

    task automatic drive(input logic [47:0] val, input logic [5:0] ep, input logic ev);
        exp_t e;
        @(negedge clk);
        a   = val;
        e.p = ep;
        e.v = ev;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so pop one entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", p, v, e.p, e.v);
            end
        end
    end

    initial begin
        logic [47:0] val;
        logic [5:0]  ep;
        logic        ev;
        exp_t        e;
        int          wait_cnt;

        rst = 1'b1;
        a   = 48'hFFFF_FFFF_FFFF;
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold", p, v, 6'd0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        e.p = 6'd0;
        e.v = 1'b1;
        exp_q.push_back(e);

        // Directed boundaries with hand-computed expectations.
        drive(48'h0000_0000_0000, 6'd0,  1'b0);
        drive(48'h0000_0000_0001, 6'd47, 1'b1);
        drive(48'h8000_0000_0000, 6'd0,  1'b1);
        drive(48'h0000_0080_0000, 6'd24, 1'b1);
        drive(48'h0100_0000_0000, 6'd7,  1'b1);
        drive(48'h0080_0000_0000, 6'd8,  1'b1);
        drive(48'h0000_0000_0100, 6'd39, 1'b1);
        drive(48'h0000_0000_0080, 6'd40, 1'b1);
        drive(48'h0001_FFFF_FFFF, 6'd15, 1'b1);
        drive(48'hFFFF_FFFF_FFFF, 6'd0,  1'b1);
        drive(48'h0000_00FF_0000, 6'd24, 1'b1);

        // Walking one, back to back.
        for (int i = 0; i < 48; i++) begin
            val = 48'd1 << i;
            drive(val, 6'(47 - i), 1'b1);
        end

        // Random sweep with an asynchronous reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            val = {$urandom(), $urandom()} >> $urandom_range(0, 48);
            ref_lzc(val, ep, ev);
            drive(val, ep, ev);
            if (i == 5000) begin
                #2;
                rst = 1'b1;
                #1;
                check("async_reset", p, v, 6'd0, 1'b0);
                exp_q.delete();
                @(posedge clk);
                #2;
                check("reset_over_edge", p, v, 6'd0, 1'b0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lzd_forty_eight.md
# lzd_forty_eight

Registered 48-bit leading-zero detector. It counts the leading zeros of an unsigned 48-bit word and flags whether the word is nonzero. It is the normalisation front end of the natural-log datapath, which left-shifts the input by the count to form the mantissa and scales ln2 by the same count. Outputs are registered, so the result appears one cycle after the input is sampled.

## Interface
- No parameters; the width is fixed at 48.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- a  in  48  unsigned operand, bit 47 is the MSB; sampled on each rising clk edge.
- p  out  6  leading-zero count of a, range 0..47; a registered output.
- v  out  1  high when a != 0; a registered output.

## Operation
- Leading-zero count: p = 47 − (index of the highest set bit of a).
  - a[47]=1 gives p=0.
  - a=1 gives p=47.
- Valid flag: v = |a.
- Zero input: when a==0, v=0 and p=0. The downstream log block handles zero separately, so p carries no meaning when v=0.
- Required structure is a two-level tree:
  - Six 8-bit group detectors. Group g covers a[47−8g : 40−8g].
  - Each group detector outputs a 3-bit in-group count and a group-nonzero flag. The in-group count is 0 when bit (47−8g) is set and 7 when only the group LSB is set.
  - A 6-input priority combiner selects the first nonzero group k, counting from the MSB side.
  - The combiner forms p = 8k + in-group count of group k, and v = OR of all group flags.
- Width rules:
  - 8k is at most 40 and the in-group count is at most 7, so the sum is at most 47 and fits in 6 bits.
  - No saturation or wrap logic is needed.
- The logic is purely combinational from a to the output register. It has no state machine and keeps no history between samples.

## Timing
- Latency is 1 cycle: a sampled at edge N appears on p and v after edge N.
- Throughput is one new operand per cycle, with no handshake and no stall.
- Reset:
  - While rst is high, p=0 and v=0, asynchronously and independent of clk.
  - Reset asserted mid-stream clears the outputs immediately; the in-flight result is discarded.
  - After rst is released, the first result is from the a sampled at the first rising edge with rst low.
- Back-to-back operand changes each produce an independent result on the following cycle.
- The combinational path (group detectors, then the priority mux and add) must close timing at the datapath clock without extra pipelining.

## Test plan
- Reset check: assert rst with a=48'hFFFF_FFFF_FFFF.
  - Required: p=0, v=0 while rst is high.
  - Deassert rst, clock once: required p=0, v=1.
- Boundaries, each applied on its own cycle and checked one cycle later:
  - a=0: required v=0, p=0.
  - a=48'h0000_0000_0001: required v=1, p=47.
  - a=48'h8000_0000_0000: required v=1, p=0.
- Group boundary, a=48'h0000_0080_0000 (only bit 23 set): required p=24, v=1.
  - Also check the single-bit inputs at bits 40, 39, 8 and 7. Required p=7, 8, 39 and 40 respectively.
- Lower bits ignored: a=48'h0001_FFFF_FFFF. Required p=15, v=1; the lower ones must not affect the count.
- Walking one: a = 1<<i for i=0..47 on consecutive cycles.
  - Required p = 47−i and v=1, each one cycle after the input.
  - No bubbles are allowed.
- Random sweep and mid-stream reset:
  - Apply 10k random 48-bit values and compare against a reference count of leading zeros plus the nonzero flag.
  - Pulse rst asynchronously mid-sequence (between clock edges). Required: p=0, v=0 immediately, then correct results resume after release.
